// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, MEM first.
// Latency: an N-byte read completes N+2 cycles after grant, an N-byte write N+1.
// Backpressure: the requester holds req until its done pulse; the loser stalls, no preemption.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [31:0]           if_data,
   output logic                  if_done,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [1:0]            mem_len,
   input  logic [31:0]           mem_wdata,
   output logic [31:0]           mem_rdata,
   output logic                  mem_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wr,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din,
   output logic                  if_stall_req,
   output logic                  me_stall_req
);

   typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [2:0]            len_q, len_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           buf_q, buf_d;
   logic [31:0]           if_data_q, if_data_d;
   logic [31:0]           mem_rdata_q, mem_rdata_d;
   logic                  if_done_q, if_done_d;
   logic                  mem_done_q, mem_done_d;
   logic                  ram_wr_q, ram_wr_d;
   logic [7:0]            ram_dout_q, ram_dout_d;

   logic [2:0]            next_k;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-1:0] nxt_addr;

   // Next-state logic: grant in IDLE, then walk the latched base address one byte per cycle.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      ram_addr_d  = ram_addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      ram_wr_d    = ram_wr_q;
      ram_dout_d  = ram_dout_q;
      next_k      = cnt_q + 3'd1;
      // Byte returning this cycle belongs to the address driven one cycle earlier.
      lane        = 2'(cnt_q - 3'd1);
      nxt_addr    = base_q + ADDR_WIDTH'(next_k);

      case (state_q)
         IDLE: begin
            ram_wr_d   = 1'b0;
            ram_addr_d = '0;
            ram_dout_d = 8'h00;
            cnt_d      = 3'd0;
            if (mem_req) begin
               base_d     = mem_addr;
               len_d      = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
               wdata_d    = mem_wdata;
               buf_d      = 32'h0;
               ram_addr_d = mem_addr;
               if (mem_we) begin
                  state_d    = MEM_WR;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = mem_wdata[7:0];
               end else begin
                  state_d = MEM_RD;
               end
            end else if (if_req) begin
               base_d     = if_addr;
               len_d      = 3'd4;
               buf_d      = 32'h0;
               ram_addr_d = if_addr;
               state_d    = IF_RD;
            end
         end
         IF_RD, MEM_RD: begin
            cnt_d = next_k;
            if (cnt_q != 3'd0) begin
               buf_d[{lane, 3'b000} +: 8] = ram_din;
            end
            if (next_k < len_q) begin
               ram_addr_d = nxt_addr;
            end else begin
               ram_addr_d = '0;
            end
            // Extra capture cycle after the last address has just taken the final byte.
            if (cnt_q == len_q) begin
               state_d = DONE;
               cnt_d   = 3'd0;
               if (state_q == IF_RD) begin
                  if_data_d = buf_d;
                  if_done_d = 1'b1;
               end else begin
                  mem_rdata_d = buf_d;
                  mem_done_d  = 1'b1;
               end
            end
         end
         MEM_WR: begin
            if (next_k < len_q) begin
               cnt_d      = next_k;
               ram_addr_d = nxt_addr;
               ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
            end else begin
               cnt_d      = 3'd0;
               ram_wr_d   = 1'b0;
               ram_addr_d = '0;
               ram_dout_d = 8'h00;
               state_d    = DONE;
               mem_done_d = 1'b1;
            end
         end
         DONE: begin
            // Requests are not looked at here; the requester drops req on this edge.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         ram_addr_q  <= '0;
         len_q       <= 3'd0;
         cnt_q       <= 3'd0;
         wdata_q     <= 32'h0;
         buf_q       <= 32'h0;
         if_data_q   <= 32'h0;
         mem_rdata_q <= 32'h0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         ram_addr_q  <= ram_addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
      end
   end

   assign if_data      = if_data_q;
   assign if_done      = if_done_q;
   assign mem_rdata    = mem_rdata_q;
   assign mem_done     = mem_done_q;
   assign ram_addr     = ram_addr_q;
   assign ram_wr       = ram_wr_q;
   assign ram_dout     = ram_dout_q;
   assign if_stall_req = if_req & ~if_done_q;
   assign me_stall_req = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte RAM model that answers one cycle late.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_len;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        if_stall_req;
   logic        me_stall_req;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_data      (if_data),
      .if_done      (if_done),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_len      (mem_len),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_done     (mem_done),
      .ram_addr     (ram_addr),
      .ram_wr       (ram_wr),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din),
      .if_stall_req (if_stall_req),
      .me_stall_req (me_stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Initial RAM image; bytes written by the DUT override it.
   function automatic logic [7:0] rom(input logic [31:0] a);
      case (a)
         32'h0000_1000: rom = 8'h13;
         32'h0000_1001: rom = 8'h05;
         32'h0000_2000: rom = 8'hEF;
         32'h0000_2001: rom = 8'hBE;
         32'h0000_2002: rom = 8'hAD;
         32'h0000_2003: rom = 8'hDE;
         32'h0000_3000: rom = 8'h80;
         32'h0000_3001: rom = 8'h7F;
         32'h0000_6000: rom = 8'hEF;
         32'h0000_6001: rom = 8'hBE;
         32'h0000_6002: rom = 8'hAD;
         32'h0000_6003: rom = 8'hDE;
         32'hFFFF_FFFE: rom = 8'h11;
         32'hFFFF_FFFF: rom = 8'h22;
         32'h0000_0000: rom = 8'h33;
         32'h0000_0001: rom = 8'h44;
         default:       rom = 8'h00;
      endcase
   endfunction

   logic [7:0] wmem [logic [31:0]];

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (wmem.exists(a)) ram_rd = wmem[a];
      else ram_rd = rom(a);
   endfunction

   always @(posedge clk) begin
      if (ram_wr) wmem[ram_addr] = ram_dout;
      ram_din <= ram_rd(ram_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_if;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_done;
   } vec_t;

   // One isolated request from C0 (grant cycle) through its done pulse and the cycle after.
   task automatic run_vec(input vec_t v, input int idx);
      int          n;
      logic [31:0] wd;
      n  = v.is_if ? 4 : (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
      wd = v.wdata;
      @(posedge clk); #1;
      if (v.is_if) begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end else begin
         mem_req   = 1'b1;
         mem_we    = v.we;
         mem_addr  = v.addr;
         mem_len   = v.len;
         mem_wdata = v.wdata;
      end
      for (int c = 0; c <= v.exp_done; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= n) begin
            chk($sformatf("v%0d ram_addr c%0d", idx, c), ram_addr, v.addr + 32'(c - 1));
            chk($sformatf("v%0d ram_wr c%0d", idx, c), {31'h0, ram_wr}, {31'h0, v.we});
            if (v.we) chk($sformatf("v%0d ram_dout c%0d", idx, c), {24'h0, ram_dout},
                          {24'h0, wd[8*(c-1) +: 8]});
         end
         if (c < v.exp_done) begin
            chk($sformatf("v%0d done low c%0d", idx, c),
                {31'h0, (v.is_if ? if_done : mem_done)}, 32'h0);
            chk($sformatf("v%0d stall c%0d", idx, c),
                {31'h0, (v.is_if ? if_stall_req : me_stall_req)}, 32'h1);
         end else begin
            chk($sformatf("v%0d done pulse", idx),
                {31'h0, (v.is_if ? if_done : mem_done)}, 32'h1);
            chk($sformatf("v%0d stall at done", idx),
                {31'h0, (v.is_if ? if_stall_req : me_stall_req)}, 32'h0);
            chk($sformatf("v%0d data", idx), (v.is_if ? if_data : mem_rdata), v.exp_data);
         end
      end
      @(posedge clk); #1;
      if_req  = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", idx), {31'h0, (v.is_if ? if_done : mem_done)}, 32'h0);
   endtask

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_1000, 2'd2, 32'h0,          32'h0000_0513, 6};
      vecs[1]  = '{1'b0, 1'b0, 32'h0000_2000, 2'd2, 32'h0,          32'hDEAD_BEEF, 6};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_2002, 2'd1, 32'h1234_BEEF,  32'hDEAD_BEEF, 3};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_2000, 2'd3, 32'h0,          32'hBEEF_BEEF, 6};
      vecs[4]  = '{1'b0, 1'b0, 32'h0000_3000, 2'd0, 32'h0,          32'h0000_0080, 3};
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_3000, 2'd1, 32'h0,          32'h0000_7F80, 4};
      vecs[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0,          32'h4433_2211, 6};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_4000, 2'd0, 32'h0000_00A5,  32'h4433_2211, 2};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_5000, 2'd3, 32'hCAFE_F00D,  32'h4433_2211, 5};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_5000, 2'd2, 32'h0,          32'hCAFE_F00D, 6};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_4000, 2'd0, 32'h0,          32'h0000_00A5, 3};
      vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 2'd0, 32'h0,          32'h4433_2211, 6};

      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_len   = 2'd0;
      mem_wdata = 32'h0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst if_data", if_data, 32'h0);
      chk("rst mem_rdata", mem_rdata, 32'h0);
      chk("rst ram_addr", ram_addr, 32'h0);
      chk("rst ram_wr", {31'h0, ram_wr}, 32'h0);
      chk("rst ram_dout", {24'h0, ram_dout}, 32'h0);
      chk("rst if_done", {31'h0, if_done}, 32'h0);
      chk("rst mem_done", {31'h0, mem_done}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Completed data is held across the other requester's transfers
      chk("hold mem_rdata after IF", mem_rdata, 32'h0000_00A5);
      chk("hold if_data", if_data, 32'h4433_2211);

      // Simultaneous requests: MEM first, IF granted in the IDLE after MEM's done
      @(posedge clk); #1;
      if_req   = 1'b1;
      if_addr  = 32'h0000_1000;
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 32'h0000_6000;
      mem_len  = 2'd2;
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) chk("both: MEM addr first", ram_addr, 32'h0000_6000);
         if (c < 6) chk($sformatf("both: me_stall c%0d", c), {31'h0, me_stall_req}, 32'h1);
         if (c == 6) begin
            chk("both: mem_done", {31'h0, mem_done}, 32'h1);
            chk("both: mem_rdata", mem_rdata, 32'hDEAD_BEEF);
         end
         if (c == 7) chk("both: mem_done one cycle", {31'h0, mem_done}, 32'h0);
         if (c == 8) chk("both: IF addr", ram_addr, 32'h0000_1000);
         if (c < 13) begin
            chk($sformatf("both: if_stall c%0d", c), {31'h0, if_stall_req}, 32'h1);
            chk($sformatf("both: if_done low c%0d", c), {31'h0, if_done}, 32'h0);
         end else begin
            chk("both: if_done", {31'h0, if_done}, 32'h1);
            chk("both: if_data", if_data, 32'h0000_0513);
            chk("both: if_stall at done", {31'h0, if_stall_req}, 32'h0);
         end
         if (c == 6) begin
            @(posedge clk); #1;
            mem_req = 1'b0;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      chk("both: if_done one cycle", {31'h0, if_done}, 32'h0);

      // Reset during C2 of a word store
      @(posedge clk); #1;
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 32'h0000_7000;
      mem_len   = 2'd2;
      mem_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid: C2 ram_wr", {31'h0, ram_wr}, 32'h1);
      chk("rstmid: C2 ram_addr", ram_addr, 32'h0000_7001);
      @(posedge clk); #1;
      rst     = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
      chk("rstmid: ram_wr", {31'h0, ram_wr}, 32'h0);
      chk("rstmid: ram_addr", ram_addr, 32'h0);
      chk("rstmid: ram_dout", {24'h0, ram_dout}, 32'h0);
      chk("rstmid: if_data", if_data, 32'h0);
      chk("rstmid: mem_rdata", mem_rdata, 32'h0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rstmid: no mem_done %0d", c), {31'h0, mem_done}, 32'h0);
         chk($sformatf("rstmid: no write %0d", c), {31'h0, ram_wr}, 32'h0);
         @(negedge clk);
      end
      chk("rstmid: byte 2 unwritten", {24'h0, ram_rd(32'h0000_7002)}, 32'h0);
      chk("rstmid: byte 0 written", {24'h0, ram_rd(32'h0000_7000)}, 32'h0000_000D);
      run_vec(vecs[0], 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
